// File: rtl/rim_job_scheduler.sv
// ----------------------------------------------------------------------------
// rim_job_scheduler
//
// Lets NUM_REQ requesters share one RIM maze solver. Only one job is in flight
// at a time:
//   IDLE  - round-robin pick of a pending requester, maze captured on grant
//   LOAD  - the captured 8x8 maze is streamed to the solver, one row per cycle
//   WAIT  - watchdog runs until the solver's first coordinate beat arrives
//   DRAIN - solver beats are forwarded, tagged with the owner id
//   GAP   - one quiet cycle before the next arbitration
// If the solver stays silent too long, or stops before PATH_LEN beats, the job
// ends with a single error beat (rsp_err=1, rsp_last=1, row/col = 0).
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   req_valid        per-requester "maze pending"
//   req_maze         maze i = [64i+63:64i], row r of it = [64i+8r+7:64i+8r]
//   req_ready        one-hot, one-cycle grant; the maze is captured on that edge
//   slv_in_valid     solver load strobe, high for the 8 row cycles
//   slv_maze         row data to the solver
//   slv_out_valid    solver coordinate beat valid
//   slv_out_row/col  solver coordinate
//   rsp_valid        response beat valid (no backpressure)
//   rsp_id           owner of the job the beat belongs to
//   rsp_row/col      forwarded coordinate (0 on an error beat)
//   rsp_last         final beat of a job (normal or error)
//   rsp_err          job aborted
//   busy             a job is in progress (state is not IDLE)
// All outputs are registered.
// ----------------------------------------------------------------------------
module rim_job_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int PATH_LEN = 15,
  parameter int TIMEOUT  = 256,
  parameter int IDW      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*64-1:0] req_maze,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  slv_in_valid,
  output logic [7:0]            slv_maze,
  input  logic                  slv_out_valid,
  input  logic [2:0]            slv_out_row,
  input  logic [2:0]            slv_out_col,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [2:0]            rsp_row,
  output logic [2:0]            rsp_col,
  output logic                  rsp_last,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(PATH_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] LAST_REQ  = PW'(NUM_REQ - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(PATH_LEN - 1);
  localparam logic [WW-1:0] WDOG_LIM  = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WDOG_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [IDW-1:0]  job_id;
  logic [63:0]     maze_reg;
  logic [2:0]      row_cnt;
  logic [BW-1:0]   beat_cnt;
  logic [WW-1:0]   wdog;

  // Per-requester maze view and per-row view of the captured maze.
  logic [63:0] maze_in [NUM_REQ];
  logic [7:0]  maze_row [8];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_maze_in
    assign maze_in[gi] = req_maze[64*gi +: 64];
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_maze_row
    assign maze_row[gi] = maze_reg[8*gi +: 8];
  end

  // Round-robin arbiter: candidate gi is requester (rr_ptr + gi) mod NUM_REQ,
  // so the lowest-numbered hit is the first pending requester at or after
  // rr_ptr, wrapping around.
  logic [PW-1:0]      cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;
  logic               grant_any;
  logic [PW-1:0]      grant_idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [PW:0] sum;
    assign sum = {1'b0, rr_ptr} + (PW+1)'(gi);
    assign cand_idx[gi] = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ))
                                                    : sum[PW-1:0];
    assign cand_hit[gi] = req_valid[cand_idx[gi]];
  end

  always_comb begin
    grant_any = |cand_hit;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant_idx = cand_idx[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      job_id       <= '0;
      maze_reg     <= '0;
      row_cnt      <= '0;
      beat_cnt     <= '0;
      wdog         <= '0;
      req_ready    <= '0;
      slv_in_valid <= 1'b0;
      slv_maze     <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_row      <= '0;
      rsp_col      <= '0;
      rsp_last     <= 1'b0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Strobes are single-cycle; rsp_id/row/col keep their last value.
      req_ready    <= '0;
      slv_in_valid <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_last     <= 1'b0;
      rsp_err      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_any) begin
            req_ready <= NUM_REQ'(1) << grant_idx;
            maze_reg  <= maze_in[grant_idx];
            job_id    <= IDW'(grant_idx);
            rr_ptr    <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
            row_cnt   <= '0;
            beat_cnt  <= '0;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          // Stray solver beats here are deliberately ignored.
          slv_in_valid <= 1'b1;
          slv_maze     <= maze_row[row_cnt];
          row_cnt      <= row_cnt + 1'b1;
          if (row_cnt == 3'd7) begin
            wdog  <= '0;
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (slv_out_valid) begin
            rsp_valid <= 1'b1;
            rsp_id    <= job_id;
            rsp_row   <= slv_out_row;
            rsp_col   <= slv_out_col;
            beat_cnt  <= BW'(1);
            if (LAST_BEAT == '0) begin
              rsp_last <= 1'b1;
              state    <= S_GAP;
            end else begin
              state <= S_DRAIN;
            end
          end else if (wdog == WDOG_LIM) begin
            // Solver never answered: close the job with an error beat.
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_last  <= 1'b1;
            rsp_id    <= job_id;
            rsp_row   <= '0;
            rsp_col   <= '0;
            state     <= S_GAP;
          end else if (wdog != WDOG_MAX) begin
            wdog <= wdog + 1'b1;
          end
        end

        S_DRAIN: begin
          if (slv_out_valid) begin
            rsp_valid <= 1'b1;
            rsp_id    <= job_id;
            rsp_row   <= slv_out_row;
            rsp_col   <= slv_out_col;
            beat_cnt  <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              rsp_last <= 1'b1;
              state    <= S_GAP;
            end
          end else begin
            // Burst ended early: replace the missing beats with one error beat.
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_last  <= 1'b1;
            rsp_id    <= job_id;
            rsp_row   <= '0;
            rsp_col   <= '0;
            state     <= S_GAP;
          end
        end

        S_GAP: begin
          // Late solver beats (beyond PATH_LEN) land here and are dropped.
          beat_cnt <= '0;
          wdog     <= '0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
